// File: rtl/exec_core_pkg.sv
// Shared encodings for the execution core: ALU operation codes, ALUOp
// values from the main controller, and R-type funct fields.
package exec_core_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OTHER = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam int ADDR_W = 5;

endpackage

// File: rtl/exec_core_alu32.sv
// Combinational ALU: AND, OR, ADD, SUB and signed SLT with carry,
// overflow and zero flags.
module alu32
  import exec_core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             zero_o
);

  logic             subtract;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             is_arith;

  // SLT shares the subtractor so its sign/overflow can form the compare.
  assign subtract = (op_i == OP_SUB) || (op_i == OP_SLT);
  assign b_eff    = subtract ? ~b_i : b_i;
  assign sum      = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};
  assign add_ovf  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign is_arith = (op_i == OP_ADD) || (op_i == OP_SUB);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_ADD:  result_o = sum[WIDTH-1:0];
      OP_SUB:  result_o = sum[WIDTH-1:0];
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: result_o = sum[WIDTH-1:0];
    endcase
  end

  assign cout_o     = is_arith & sum[WIDTH];
  assign overflow_o = is_arith & add_ovf;
  assign zero_o     = (result_o == '0);

endmodule

// File: rtl/exec_core_alu_ctrl.sv
// ALU-control decoder: maps ALUOp and funct to a 3-bit ALU operation.
module alu_ctrl
  import exec_core_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] operation_o
);

  always_comb begin
    operation_o = OP_ADD;
    case (alu_op_i)
      ALUOP_MEM:   operation_o = OP_ADD;
      ALUOP_BEQ:   operation_o = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: operation_o = OP_ADD;
          FUNCT_SUB: operation_o = OP_SUB;
          FUNCT_AND: operation_o = OP_AND;
          FUNCT_OR:  operation_o = OP_OR;
          FUNCT_SLT: operation_o = OP_SLT;
          default:   operation_o = OP_ADD;
        endcase
      end
      ALUOP_OTHER: operation_o = OP_ADD;
      default:     operation_o = OP_ADD;
    endcase
  end

endmodule

// File: rtl/exec_core_regfile32.sv
// Register file: two combinational read ports, one write port, r0 hardwired
// to zero, asynchronous clear of every register.
module regfile32
  import exec_core_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              we_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign regs_q[gi] = '0;
    end else begin : g_store
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs_q[gi] <= '0;
        end else if (we_i && (rd_addr_i == ADDR_W'(gi))) begin
          regs_q[gi] <= wdata_i;
        end
      end
    end
  end

  // No bypass: a same-cycle write is only visible after the edge.
  assign rd1_o = regs_q[rs_addr_i];
  assign rd2_o = regs_q[rt_addr_i];

endmodule

// File: rtl/exec_core.sv
// Single-cycle execution core: register file feeding the ALU, with the
// ALU result or an external word selected for write-back.
module exec_core
  import exec_core_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic [4:0]       rd_addr,
  input  logic             reg_write,
  input  logic             wr_src,
  input  logic [WIDTH-1:0] ext_wdata,
  input  logic             alu_op0,
  input  logic             alu_op1,
  input  logic [5:0]       funct,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2,
  output logic [2:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH-1:0] wdata;

  assign wdata = wr_src ? ext_wdata : result;

  regfile32 #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rs_addr_i (rs_addr),
    .rt_addr_i (rt_addr),
    .rd_addr_i (rd_addr),
    .we_i      (reg_write),
    .wdata_i   (wdata),
    .rd1_o     (read_data1),
    .rd2_o     (read_data2)
  );

  alu_ctrl u_alu_ctrl (
    .alu_op_i    ({alu_op1, alu_op0}),
    .funct_i     (funct),
    .operation_o (operation)
  );

  alu32 #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i        (read_data1),
    .b_i        (read_data2),
    .op_i       (operation),
    .result_o   (result),
    .cout_o     (cout),
    .overflow_o (overflow),
    .zero_o     (zero)
  );

endmodule

// File: tb/tb_exec_core.sv
// Directed self-checking bench for exec_core with hand-computed expectations.
module tb_exec_core;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        wr_src;
  logic [31:0] ext_wdata;
  logic        alu_op0;
  logic        alu_op1;
  logic [5:0]  funct;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [2:0]  operation;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

  exec_core #(.WIDTH(32), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .reg_write  (reg_write),
    .wr_src     (wr_src),
    .ext_wdata  (ext_wdata),
    .alu_op0    (alu_op0),
    .alu_op1    (alu_op1),
    .funct      (funct),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .operation  (operation),
    .result     (result),
    .cout       (cout),
    .overflow   (overflow),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic write_ext(input logic [4:0] rd, input logic [31:0] val);
    rd_addr   = rd;
    ext_wdata = val;
    wr_src    = 1'b1;
    reg_write = 1'b1;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  task automatic set_op(input logic [1:0] aluop, input logic [5:0] f,
                        input logic [4:0] rs, input logic [4:0] rt);
    {alu_op1, alu_op0} = aluop;
    funct   = f;
    rs_addr = rs;
    rt_addr = rt;
    #1;
  endtask

  initial begin
    reset = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
    reg_write = 1'b0; wr_src = 1'b0; ext_wdata = 32'd0;
    alu_op0 = 1'b0; alu_op1 = 1'b0; funct = 6'd0;
    #1 reset = 1'b0;

    // Reset then idle
    set_op(2'b00, 6'd0, 5'd5, 5'd9);
    check("rst_rd1", read_data1, 32'd0);
    check("rst_rd2", read_data2, 32'd0);
    check("rst_op_add", 32'(operation), 32'd2);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);

    // Load + ADD + write-back
    write_ext(5'd1, 32'd7);
    write_ext(5'd2, 32'd5);
    set_op(2'b10, 6'b100000, 5'd1, 5'd2);
    check("add_result", result, 32'd12);
    check("add_cout", 32'(cout), 32'd0);
    check("add_zero", 32'(zero), 32'd0);
    rd_addr = 5'd3; wr_src = 1'b0; reg_write = 1'b1;
    @(posedge clk); #1; reg_write = 1'b0;
    set_op(2'b10, 6'b100000, 5'd3, 5'd0);
    check("wb_r3", read_data1, 32'd12);

    // SUB via beq and SLT
    write_ext(5'd1, 32'd5);
    set_op(2'b01, 6'd0, 5'd1, 5'd2);
    check("beq_op", 32'(operation), 32'd6);
    check("beq_result", result, 32'd0);
    check("beq_zero", 32'(zero), 32'd1);
    check("beq_cout", 32'(cout), 32'd1);
    write_ext(5'd1, 32'hFFFF_FFFF);
    write_ext(5'd2, 32'd1);
    set_op(2'b10, 6'b101010, 5'd1, 5'd2);
    check("slt_op", 32'(operation), 32'd7);
    check("slt_lt", result, 32'd1);
    check("slt_cout", 32'(cout), 32'd0);
    set_op(2'b10, 6'b101010, 5'd2, 5'd1);
    check("slt_ge", result, 32'd0);
    check("slt_zero", 32'(zero), 32'd1);

    // AND / OR / overflow
    write_ext(5'd1, 32'hF0F0_F0F0);
    write_ext(5'd2, 32'h0FF0_0FF0);
    set_op(2'b10, 6'b100100, 5'd1, 5'd2);
    check("and_result", result, 32'h00F0_00F0);
    set_op(2'b10, 6'b100101, 5'd1, 5'd2);
    check("or_result", result, 32'hFFF0_FFF0);
    set_op(2'b10, 6'b100010, 5'd1, 5'd2);
    check("sub_rtype", result, 32'hE100_E100);
    write_ext(5'd1, 32'h7FFF_FFFF);
    write_ext(5'd2, 32'd1);
    set_op(2'b10, 6'b100000, 5'd1, 5'd2);
    check("ovf_result", result, 32'h8000_0000);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_cout", 32'(cout), 32'd0);
    set_op(2'b10, 6'b000000, 5'd1, 5'd2);
    check("bad_funct_op", 32'(operation), 32'd2);
    set_op(2'b11, 6'b100100, 5'd1, 5'd2);
    check("aluop11_op", 32'(operation), 32'd2);
    set_op(2'b10, 6'b100100, 5'd1, 5'd2);
    check("and_no_ovf", 32'(overflow), 32'd0);

    // Register 0 and no-bypass
    write_ext(5'd0, 32'h0000_DEAD);
    set_op(2'b00, 6'd0, 5'd0, 5'd0);
    check("r0_zero", read_data1, 32'd0);
    rs_addr = 5'd4; rd_addr = 5'd4; wr_src = 1'b1;
    ext_wdata = 32'h0000_1234; reg_write = 1'b1;
    #1;
    check("r4_before", read_data1, 32'd0);
    @(posedge clk); #1; reg_write = 1'b0;
    check("r4_after", read_data1, 32'h0000_1234);

    // Async reset mid-cycle
    @(negedge clk);
    #2;
    reset = 1'b1;
    set_op(2'b00, 6'd0, 5'd1, 5'd2);
    check("arst_r1", read_data1, 32'd0);
    check("arst_r2", read_data2, 32'd0);
    set_op(2'b01, 6'd0, 5'd3, 5'd4);
    check("arst_r3", read_data1, 32'd0);
    check("arst_r4", read_data2, 32'd0);
    check("arst_sub_cout", 32'(cout), 32'd1);
    check("arst_sub_zero", 32'(zero), 32'd1);
    rd_addr = 5'd5; wr_src = 1'b1; ext_wdata = 32'h0000_ABCD; reg_write = 1'b1;
    @(posedge clk); #1;
    rs_addr = 5'd5; #1;
    check("arst_blocked", read_data1, 32'd0);
    reg_write = 1'b0; reset = 1'b0; #1;
    check("arst_after", read_data1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
